// File: rtl/ibex_csr_access_pkg.sv
// Shared types and the read-modify-write helper for the CSR access sequencer.
package ibex_csr_access_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } csr_acc_state_e;

  // Bitwise, so the module applies it across any data width.
  function automatic logic csr_modify(input logic old_bit, input logic wdata_bit,
                                      input csr_op_e op);
    logic new_bit;
    case (op)
      CSR_OP_READ:  new_bit = old_bit;
      CSR_OP_WRITE: new_bit = wdata_bit;
      CSR_OP_SET:   new_bit = old_bit | wdata_bit;
      CSR_OP_CLEAR: new_bit = old_bit & ~wdata_bit;
      default:      new_bit = old_bit;
    endcase
    return new_bit;
  endfunction

endpackage

// File: rtl/ibex_csr_access.sv
// Single-outstanding CSR read-modify-write sequencer between the ID stage
// and a bank of single-register CSR storage instances.
module ibex_csr_access #(
  parameter int unsigned Width     = 32,
  parameter int unsigned NumCsr    = 8,
  parameter int unsigned AddrWidth = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_op_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [Width-1:0]        req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [Width-1:0]        rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [NumCsr-1:0]       csr_wr_en_o,
  output logic [Width-1:0]        csr_wr_data_o,
  input  logic [NumCsr*Width-1:0] csr_rd_data_i,
  input  logic [NumCsr-1:0]       csr_rd_error_i
);
  import ibex_csr_access_pkg::*;

  localparam logic [AddrWidth:0] NumCsrW = (AddrWidth+1)'(NumCsr);

  csr_acc_state_e         state_r;
  csr_op_e                op_r;
  logic [AddrWidth-1:0]   addr_r;
  logic [Width-1:0]       wdata_r;
  logic [Width-1:0]       old_r;
  logic                   err_r;
  logic                   req_ready_r;
  logic                   rsp_valid_r;
  logic [Width-1:0]       rsp_rdata_r;
  logic                   rsp_err_r;
  logic [NumCsr-1:0]      wr_en_r;
  logic [Width-1:0]       wr_data_r;

  logic [Width-1:0]       old_s;
  logic                   rd_err_s;
  logic                   in_range_s;
  logic                   err_s;
  logic [Width-1:0]       new_s;
  logic                   do_write_s;
  logic [NumCsr-1:0]      wr_en_s;

  // Select the addressed CSR with an AND-OR mux so out-of-range addresses read 0 without indexing past the bank.
  always_comb begin
    old_s    = {Width{1'b0}};
    rd_err_s = 1'b0;
    new_s    = {Width{1'b0}};
    for (int k = 0; k < NumCsr; k++) begin
      old_s    = old_s | (csr_rd_data_i[k*Width +: Width] & {Width{addr_r == AddrWidth'(k)}});
      rd_err_s = rd_err_s | (csr_rd_error_i[k] & (addr_r == AddrWidth'(k)));
    end
    in_range_s = ({1'b0, addr_r} < NumCsrW);
    err_s      = ~in_range_s | rd_err_s;
    for (int i = 0; i < Width; i++) begin
      new_s[i] = csr_modify(old_s[i], wdata_r[i], op_r);
    end
    // SET/CLEAR with a zero mask cannot change the CSR, so skip the write.
    do_write_s = ~err_s & ((op_r == CSR_OP_WRITE) |
                 (((op_r == CSR_OP_SET) | (op_r == CSR_OP_CLEAR)) & (wdata_r != {Width{1'b0}})));
    wr_en_s    = NumCsr'(1'b1) << addr_r;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      op_r        <= CSR_OP_READ;
      addr_r      <= {AddrWidth{1'b0}};
      wdata_r     <= {Width{1'b0}};
      old_r       <= {Width{1'b0}};
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {Width{1'b0}};
      rsp_err_r   <= 1'b0;
      wr_en_r     <= {NumCsr{1'b0}};
      wr_data_r   <= {Width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            op_r        <= csr_op_e'(req_op_i);
            addr_r      <= req_addr_i;
            wdata_r     <= req_wdata_i;
            req_ready_r <= 1'b0;
            state_r     <= READ;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        READ: begin
          old_r <= old_s;
          err_r <= err_s;
          if (do_write_s) begin
            wr_en_r   <= wr_en_s;
            wr_data_r <= new_s;
            state_r   <= WRITE;
          end else begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= old_s;
            rsp_err_r   <= err_s;
            state_r     <= RESP;
          end
        end
        WRITE: begin
          wr_en_r     <= {NumCsr{1'b0}};
          wr_data_r   <= {Width{1'b0}};
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= old_r;
          rsp_err_r   <= err_r;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {Width{1'b0}};
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          wr_en_r     <= {NumCsr{1'b0}};
          wr_data_r   <= {Width{1'b0}};
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {Width{1'b0}};
          rsp_err_r   <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_rdata_r;
  assign rsp_err_o     = rsp_err_r;
  assign csr_wr_en_o   = wr_en_r;
  assign csr_wr_data_o = wr_data_r;

endmodule

// File: doc/ibex_csr_access.md
Name: ibex_csr_access

Overview:
- Access sequencer that drives a bank of NumCsr single-register CSR storage instances, each with its own write enable, shared write data, per-CSR read data and per-CSR read-error flag.
- Accepts one CSR operation at a time from the pipeline over a valid/ready request channel and performs an atomic read-modify-write.
- Returns the pre-write value and an error flag over a valid/ready response channel.
- Sits between the decode/ID stage and the CSR storage bank.

Parameters:
- Width, 32, data width of every CSR.
- NumCsr, 8, number of attached CSRs (1..2**AddrWidth, not required to be a power of two).
- AddrWidth, 3, width of req_addr_i.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
- req_op_i  in  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR
- req_addr_i  in  AddrWidth  CSR index
- req_wdata_i  in  Width  operand
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
- rsp_rdata_o  out  Width  old CSR value (0 on out-of-range address)
- rsp_err_o  out  1  error: shadow mismatch or out-of-range address
- csr_wr_en_o  out  NumCsr  per-CSR write enable, one-hot or zero
- csr_wr_data_o  out  Width  shared write data
- csr_rd_data_i  in  NumCsr*Width  concatenated CSR values, CSR k at bits [k*Width +: Width]
- csr_rd_error_i  in  NumCsr  per-CSR shadow-mismatch flag

Behaviour:
- Reset: rst_ni asynchronous, active-low, clock clk_i. Reset forces state IDLE. All outputs are 0 in reset except req_ready_o, which is 1 once in IDLE.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready_o=1. On handshake, latch op, addr and wdata, then go to READ. req_ready_o=0 in every other state, so there is exactly one operation outstanding.
- READ (1 cycle):
  - Capture old = csr_rd_data_i[addr].
  - err = (addr >= NumCsr) | csr_rd_error_i[addr]. For an out-of-range address, use old = 0 and do not index csr_rd_error_i.
  - new value: WRITE = wdata; SET = old | wdata; CLEAR = old & ~wdata.
  - do_write = !err & (op==WRITE | ((op==SET | op==CLEAR) & wdata != 0)).
  - Go to WRITE if do_write, else go to RESP.
- WRITE (1 cycle): csr_wr_en_o[addr]=1 and csr_wr_data_o=new, then go to RESP.
  - csr_wr_en_o is 0 in every other state.
  - csr_wr_data_o is 0 outside WRITE.
- RESP: rsp_valid_o=1, rsp_rdata_o=old, rsp_err_o=err. These stay stable until rsp_ready_i, then go to IDLE.
  - rsp_rdata_o and rsp_err_o are 0 when rsp_valid_o=0.
- Latency, with request accepted at cycle T:
  - rsp_valid_o at T+3 with a write.
  - rsp_valid_o at T+2 without a write.
  - The next request can be accepted the cycle after the response handshake.
- Error: no write is ever issued. rsp_rdata_o still returns the captured old value (0 if out of range).
- Reset mid-operation: the operation is abandoned with no pending write or response. After reset no write occurs until a new request is accepted.
- Request inputs are ignored outside IDLE; changes to them have no effect.
- A write to CSR k becomes visible on csr_rd_data_i the cycle after WRITE. A back-to-back request to the same CSR reads the updated value.

Decomposition:
- Shared package ibex_csr_access_pkg holds:
  - enum csr_op_e (CSR_OP_READ=2'b00, CSR_OP_WRITE, CSR_OP_SET, CSR_OP_CLEAR);
  - enum csr_acc_state_e (IDLE, READ, WRITE, RESP).
- The modify function (old, wdata, op -> new) also lives in the package.
- No sub-module needed. The bench instantiates NumCsr ibex_csr storage instances (ShadowCopy=1) around the DUT.

Test Plan:
- Reset, CSR2 holding 0x0000_00F0; request WRITE addr=2 wdata=0x1234_5678 -> csr_wr_en_o=8'b0000_0100 with data 0x1234_5678 at T+2; rsp_valid at T+3 with rdata=0x0000_00F0, err=0.
- CSR1=0x0000_00F0, SET wdata=0x0000_000F -> CSR1 becomes 0x0000_00FF, rdata=0x0000_00F0. Then CLEAR wdata=0x0000_00F0 -> CSR1 becomes 0x0000_000F, rdata=0x0000_00FF.
- SET wdata=0 and READ to CSR3 -> no csr_wr_en_o pulse, rsp_valid at T+2, rdata=current value.
- Force csr_rd_error_i[4]=1, WRITE addr=4 -> no write pulse, rsp_err_o=1, CSR4 unchanged. With NumCsr=6, WRITE addr=7 -> rdata=0, err=1, no write.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0, new request ignored.
- Assert rst_ni low during READ of a WRITE op -> no csr_wr_en_o pulse ever occurs. After release req_ready_o=1 and rsp_valid_o=0.
